// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter with one-shot or auto-reload terminal-count pulse
module down_counter_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             reload,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] rv, rv_nx, q_nx;
   logic             tc_nx, term;
   assign term = (state == RUN) && en && (Q <= WIDTH'(1));
   always_comb begin
      state_nx = state;
      q_nx     = Q;
      rv_nx    = rv;
      tc_nx    = 1'b0;
      if (load) begin
         q_nx     = load_val;
         rv_nx    = load_val;
         state_nx = (load_val != '0) ? RUN : IDLE;
      end else if (term) begin
         tc_nx    = 1'b1;
         q_nx     = reload ? rv : '0;
         state_nx = reload ? RUN : DONE;
      end else if (state == RUN && en) begin
         q_nx = Q - WIDTH'(1);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         Q     <= '0;
         rv    <= '0;
         tc    <= 1'b0;
      end else begin
         state <= state_nx;
         Q     <= q_nx;
         rv    <= rv_nx;
         tc    <= tc_nx;
      end
   end
   assign busy = (state == RUN);
   assign done = (state == DONE);
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed self-checking bench for down_counter_timer
module tb_down_counter_timer;
   localparam int W = 3;
   logic         clk = 1'b0;
   logic         rst_n, load, en, reload;
   logic [W-1:0] load_val, Q;
   logic         tc, busy, done;
   int           checks = 0;
   int           errors = 0;
   int           k;

   down_counter_timer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .en(en),
      .reload(reload), .Q(Q), .tc(tc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int q, input int t, input int b, input int d);
      chk({tag, ".Q"}, 16'(Q), 16'(q));
      chk({tag, ".tc"}, 16'(tc), 16'(t));
      chk({tag, ".busy"}, 16'(busy), 16'(b));
      chk({tag, ".done"}, 16'(done), 16'(d));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; en = 1'b0; reload = 1'b0; load_val = '0;
      #2 chk_all("reset", 0, 0, 0, 0);
      #10 rst_n = 1'b1; en = 1'b1;
      tick; chk_all("idle_after_reset", 0, 0, 0, 0);

      // one-shot 3,2,1,0
      load = 1'b1; load_val = 3'd3; reload = 1'b0; en = 1'b1;
      tick; chk_all("os_load", 3, 0, 1, 0);
      load = 1'b0;
      tick; chk_all("os_2", 2, 0, 1, 0);
      tick; chk_all("os_1", 1, 0, 1, 0);
      tick; chk_all("os_term", 0, 1, 0, 1);
      tick; chk_all("os_hold", 0, 0, 0, 1);

      // auto-reload period 2
      load = 1'b1; load_val = 3'd2; reload = 1'b1;
      tick; chk_all("ar_load", 2, 0, 1, 0);
      load = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick; chk_all($sformatf("ar%0d", i), (i % 2) ? 1 : 2, (i % 2) ? 0 : 1, 1, 0);
      end

      // enable gating from 4
      load = 1'b1; load_val = 3'd4; reload = 1'b0;
      tick; chk_all("eg_load", 4, 0, 1, 0);
      load = 1'b0; k = 0;
      for (int i = 0; i < 8; i++) begin
         en = (i % 2 == 0);
         tick;
         if (en) k++;
         chk_all($sformatf("eg%0d", i), 4 - k, (en && k == 4) ? 1 : 0, (k < 4) ? 1 : 0, (k == 4) ? 1 : 0);
      end

      // load wins over terminal event
      en = 1'b1; load = 1'b1; load_val = 3'd3; reload = 1'b1;
      tick; load = 1'b0;
      tick; tick; chk_all("pr_at1", 1, 0, 1, 0);
      load = 1'b1; load_val = 3'd5;
      tick; chk_all("pr_load", 5, 0, 1, 0);
      load = 1'b0;

      // reload only matters in terminal cycle
      load = 1'b1; load_val = 3'd2; reload = 1'b1;
      tick; load = 1'b0; reload = 1'b0;
      tick; chk_all("rs_1", 1, 0, 1, 0);
      tick; chk_all("rs_term", 0, 1, 0, 1);

      // zero load
      load = 1'b1; load_val = 3'd0;
      tick; chk_all("z_load", 0, 0, 0, 0);
      load = 1'b0;
      tick; chk_all("z_hold", 0, 0, 0, 0);

      // full scale 7
      load = 1'b1; load_val = 3'd7; reload = 1'b0;
      tick; chk_all("fs_load", 7, 0, 1, 0);
      load = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick; chk_all($sformatf("fs%0d", i), 7 - i, (i == 7) ? 1 : 0, (i < 7) ? 1 : 0, (i == 7) ? 1 : 0);
      end
      tick; chk_all("fs_after", 0, 0, 0, 1);

      // async reset mid-count at Q=2
      load = 1'b1; load_val = 3'd3;
      tick; load = 1'b0;
      tick; chk_all("ar_pre", 2, 0, 1, 0);
      #2 rst_n = 1'b0;
      #1 chk_all("ar_async", 0, 0, 0, 0);
      tick; rst_n = 1'b1;
      tick; chk_all("ar_post1", 0, 0, 0, 0);
      tick; chk_all("ar_post2", 0, 0, 0, 0);

      // reset during tc pulse
      load = 1'b1; load_val = 3'd1;
      tick; load = 1'b0;
      tick; chk_all("rt_tc", 0, 1, 0, 1);
      #2 rst_n = 1'b0;
      #1 chk_all("rt_async", 0, 0, 0, 0);
      tick; rst_n = 1'b1;
      tick; chk_all("rt_post", 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter: WIDTH, 3, counter width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: load  input  1  synchronous load strobe for load_val.
REQ-005 Port: load_val  input  WIDTH  start value; also captured as the reload value.
REQ-006 Port: en  input  1  count enable; one decrement per enabled cycle.
REQ-007 Port: reload  input  1  1 = auto-reload (periodic) mode; 0 = one-shot.
REQ-008 Port: Q  output  WIDTH  current count, registered.
REQ-009 Port: tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-010 Port: busy  output  1  high while state is RUN.
REQ-011 Port: done  output  1  high while state is DONE.

Function
REQ-012 Internal registers: Q, reload value rv (WIDTH), state in {IDLE, RUN, DONE}, tc.
REQ-013 busy and done SHALL be decoded directly from the state register, with no added latency.
REQ-014 load=1 in any state: Q<=load_val, rv<=load_val, tc<=0; next state RUN if load_val!=0, else IDLE.
REQ-015 load SHALL take priority over en and over any terminal-count event in the same cycle.
REQ-016 In RUN with en=1, load=0 and Q>1, the block SHALL apply Q<=Q-1.
REQ-017 In RUN with en=1, load=0 and Q==1 (the terminal cycle), the block SHALL assert tc<=1 for exactly the next cycle.
REQ-018 Terminal cycle with reload=1: Q<=rv, state stays RUN; period = rv enabled cycles per tc pulse.
REQ-019 Terminal cycle with reload=0: Q<=0, state<=DONE.
REQ-020 reload SHALL be sampled only in the terminal cycle; changing it mid-count has no other effect.
REQ-021 In RUN with en=0, the block SHALL hold Q and state, and tc<=0.
REQ-022 In IDLE and in DONE, the block SHALL ignore en; Q holds, state holds until load, tc<=0.
REQ-023 Q SHALL never wrap below zero; the value 2^WIDTH-1 is reached only via load.
REQ-024 tc SHALL be 0 in every cycle other than the cycle after a terminal cycle.
REQ-025 Full-scale load (load_val = 2^WIDTH-1) SHALL take exactly 2^WIDTH-1 enabled cycles to the terminal event.

Reset
REQ-026 rst_n=0 SHALL force Q=0, rv=0, tc=0, state=IDLE (busy=0, done=0) immediately, without waiting for a clock edge.
REQ-027 Reset asserted mid-count or during a tc pulse SHALL abort the operation; no tc is issued after reset.
REQ-028 After rst_n deasserts, the block SHALL remain in IDLE until the first load.

Verification
REQ-029 One-shot, WIDTH=3: load_val=3, reload=0, en=1 continuous -> Q sequence 3,2,1,0; tc=1 for one cycle in the cycle Q first reads 0; done=1 thereafter; Q holds 0.
REQ-030 Auto-reload: load_val=2, reload=1, en=1 for 8 cycles -> Q sequence 2,1,2,1,...; tc pulses every 2nd cycle; busy stays 1 throughout.
REQ-031 Enable gating: load_val=4, en toggled 1,0,1,0,... -> Q decrements only on en=1 cycles; the terminal event occurs on the 4th enabled cycle.
REQ-032 Priority: assert load (load_val=5) in the terminal cycle with reload=1 -> Q=5 next cycle, tc=0.
REQ-033 Zero and full-scale: load_val=0 -> state IDLE, Q=0, no tc; load_val=7 -> terminal event after 7 enabled cycles.
REQ-034 Async reset: pull rst_n low at Q=2 between clock edges -> Q=0, busy=0 immediately; no tc after rst_n is released.
